// File: rtl/note_sequencer.sv
// Melody sequencer: fetches note words from an external ROM, offers each note to a tone
// generator over a valid/ready handshake, then times note and gap lengths in sample-tick units.
// Build option: define NOTE_SEQUENCER_LOOP_EN to loop the song forever and count passes.
module note_sequencer #(
   parameter int SONG_LEN     = 25,
   parameter int BEAT_SAMPLES = 5468,
   parameter int SHORT_UNITS  = 3,
   parameter int LONG_UNITS   = 7,
   parameter int GAP_UNITS    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sample_tick,
   input  logic       start,
   input  logic       stop,
   output logic [4:0] rom_addr,
   input  logic [3:0] rom_data,
   output logic       tone_valid,
   input  logic       tone_ready,
   output logic [2:0] tone_note,
   output logic       tone_gate,
   output logic       busy,
   output logic [7:0] loop_count,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH     = 3'd1,
      WAIT_DATA = 3'd2,
      LOAD      = 3'd3,
      NOTE      = 3'd4,
      GAP       = 3'd5
   } state_t;

   localparam int SAMP_W    = (BEAT_SAMPLES > 1) ? $clog2(BEAT_SAMPLES) : 1;
   localparam int MAX_NOTE  = (LONG_UNITS > SHORT_UNITS) ? LONG_UNITS : SHORT_UNITS;
   localparam int MAX_UNITS = (MAX_NOTE > GAP_UNITS) ? MAX_NOTE : GAP_UNITS;
   localparam int UNIT_W    = (MAX_UNITS > 1) ? $clog2(MAX_UNITS) : 1;

   localparam logic [SAMP_W-1:0] SAMP_LAST  = SAMP_W'(BEAT_SAMPLES - 1);
   localparam logic [UNIT_W-1:0] SHORT_LAST = UNIT_W'(SHORT_UNITS - 1);
   localparam logic [UNIT_W-1:0] LONG_LAST  = UNIT_W'(LONG_UNITS - 1);
   localparam logic [UNIT_W-1:0] GAP_LAST   = UNIT_W'(GAP_UNITS - 1);
   localparam logic [4:0]        POS_LAST   = 5'(SONG_LEN - 1);

   state_t            state;
   logic [4:0]        pos;
   logic [SAMP_W-1:0] samp_cnt;
   logic [UNIT_W-1:0] unit_cnt;
   logic              long_q;
   logic [UNIT_W-1:0] note_last;
   logic              unit_done;

   assign state_dbg = state;
   assign note_last = long_q ? LONG_LAST : SHORT_LAST;
   assign unit_done = sample_tick && (samp_cnt == SAMP_LAST);

   // Handshake: tone_note is offered while tone_valid is high and is held stable until a cycle
   // in which tone_valid and tone_ready are both high; that cycle is the transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pos        <= '0;
         samp_cnt   <= '0;
         unit_cnt   <= '0;
         long_q     <= 1'b0;
         rom_addr   <= '0;
         tone_valid <= 1'b0;
         tone_note  <= '0;
         tone_gate  <= 1'b0;
         busy       <= 1'b0;
         loop_count <= '0;
      end else if (state != IDLE && stop) begin
         state      <= IDLE;
         tone_valid <= 1'b0;
         tone_gate  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start && !stop) begin
                  state    <= FETCH;
                  pos      <= '0;
                  rom_addr <= '0;
                  busy     <= 1'b1;
               end
            end
            FETCH: state <= WAIT_DATA;
            WAIT_DATA: begin
               tone_note  <= rom_data[3:1];
               long_q     <= rom_data[0];
               tone_valid <= 1'b1;
               state      <= LOAD;
            end
            LOAD: begin
               if (tone_ready) begin
                  tone_valid <= 1'b0;
                  tone_gate  <= 1'b1;
                  samp_cnt   <= '0;
                  unit_cnt   <= '0;
                  state      <= NOTE;
               end
            end
            NOTE: begin
               if (unit_done) begin
                  samp_cnt <= '0;
                  if (unit_cnt == note_last) begin
                     unit_cnt  <= '0;
                     tone_gate <= 1'b0;
                     state     <= GAP;
                  end else begin
                     unit_cnt <= unit_cnt + 1'b1;
                  end
               end else if (sample_tick) begin
                  samp_cnt <= samp_cnt + 1'b1;
               end
            end
            GAP: begin
               if (unit_done) begin
                  samp_cnt <= '0;
                  if (unit_cnt == GAP_LAST) begin
                     unit_cnt <= '0;
                     if (pos < POS_LAST) begin
                        pos      <= pos + 5'd1;
                        rom_addr <= pos + 5'd1;
                        state    <= FETCH;
                     end else begin
`ifdef NOTE_SEQUENCER_LOOP_EN
                        pos        <= '0;
                        rom_addr   <= '0;
                        loop_count <= loop_count + 8'd1;
                        state      <= FETCH;
`else
                        state <= IDLE;
                        busy  <= 1'b0;
`endif
                     end
                  end else begin
                     unit_cnt <= unit_cnt + 1'b1;
                  end
               end else if (sample_tick) begin
                  samp_cnt <= samp_cnt + 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               tone_valid <= 1'b0;
               tone_gate  <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: a 3-entry melody ROM model, a scoreboard of expected
// notes/addresses filled when playback is requested, and a negedge monitor that drains it.
module tb_note_sequencer;

   localparam int SONG_LEN     = 3;
   localparam int BEAT_SAMPLES = 4;
   localparam int SHORT_UNITS  = 3;
   localparam int LONG_UNITS   = 7;
   localparam int GAP_UNITS    = 1;
   localparam int LIMIT        = 2000;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_GAP   = 3'd5;

   logic       clk;
   logic       rst;
   logic       sample_tick;
   logic       start;
   logic       stop;
   logic [4:0] rom_addr;
   logic [3:0] rom_data;
   logic       tone_valid;
   logic       tone_ready;
   logic [2:0] tone_note;
   logic       tone_gate;
   logic       busy;
   logic [7:0] loop_count;
   logic [2:0] state_dbg;

   logic [3:0] rom [0:31];
   logic [8:0] note_exp_q [$];
   logic [4:0] addr_exp_q [$];

   int checks = 0;
   int errors = 0;

   note_sequencer #(
      .SONG_LEN(SONG_LEN), .BEAT_SAMPLES(BEAT_SAMPLES), .SHORT_UNITS(SHORT_UNITS),
      .LONG_UNITS(LONG_UNITS), .GAP_UNITS(GAP_UNITS)
   ) dut (
      .clk(clk), .rst(rst), .sample_tick(sample_tick), .start(start), .stop(stop),
      .rom_addr(rom_addr), .rom_data(rom_data), .tone_valid(tone_valid),
      .tone_ready(tone_ready), .tone_note(tone_note), .tone_gate(tone_gate),
      .busy(busy), .loop_count(loop_count), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset / ROM / tick ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom[rom_addr];

   initial begin
      sample_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1 sample_tick = rst ? 1'b0 : ~sample_tick;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- monitor / scoreboard drain ----------------
   logic [2:0] cur_note   = '0;
   int         gate_ticks = 0;
   int         gap_ticks  = 0;
   logic       prev_gate  = 1'b0;
   logic       prev_abort = 1'b0;
   logic [2:0] prev_state = S_IDLE;

   always @(negedge clk) begin
      if (tone_valid && tone_ready) cur_note = tone_note;
      if (tone_gate && sample_tick) gate_ticks++;
      if (state_dbg == S_GAP && sample_tick) gap_ticks++;
      if (prev_gate && !tone_gate) begin
         if (!prev_abort) begin
            if (note_exp_q.size() == 0) check("note_unexpected", {cur_note, 6'(gate_ticks)}, 9'h1ff);
            else check("note_and_gate_ticks", {cur_note, 6'(gate_ticks)}, note_exp_q.pop_front());
         end
         gate_ticks = 0;
      end
      if (prev_state == S_GAP && state_dbg != S_GAP) begin
         if (!prev_abort) check("gap_ticks", gap_ticks, GAP_UNITS * BEAT_SAMPLES);
         gap_ticks = 0;
      end
      if (state_dbg == S_FETCH && prev_state != S_FETCH) begin
         if (addr_exp_q.size() == 0) check("addr_unexpected", rom_addr, 5'h1f);
         else check("fetch_rom_addr", rom_addr, addr_exp_q.pop_front());
      end
      prev_gate  = tone_gate;
      prev_state = state_dbg;
      prev_abort = stop || rst;
   end

   // ---------------- driver tasks ----------------
   task automatic play(input int passes);
      for (int p = 0; p < passes; p++) begin
         for (int i = 0; i < SONG_LEN; i++) begin
            addr_exp_q.push_back(5'(i));
            note_exp_q.push_back({rom[i][3:1],
                                  6'((rom[i][0] ? LONG_UNITS : SHORT_UNITS) * BEAT_SAMPLES)});
         end
      end
`ifdef NOTE_SEQUENCER_LOOP_EN
      addr_exp_q.push_back(5'd0);
`endif
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic pulse_stop();
      @(posedge clk); #1 stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
   endtask

   task automatic finish_song(input int passes);
`ifdef NOTE_SEQUENCER_LOOP_EN
      logic [7:0] lc_target;
      lc_target = loop_count + 8'(passes);
      for (int i = 0; i < LIMIT * passes && loop_count !== lc_target; i++) @(negedge clk);
      check("loop_count_reached", loop_count, lc_target);
      check("busy_while_looping", busy, 1'b1);
      pulse_stop();
      @(negedge clk);
      check("busy_after_loop_stop", busy, 1'b0);
`else
      for (int i = 0; i < LIMIT && busy !== 1'b0; i++) @(negedge clk);
      check("busy_after_song", busy, 1'b0);
      check("loop_count_held", loop_count, 8'd0);
`endif
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      for (int i = 0; i < 32; i++) rom[i] = 4'h0;
      rom[0] = {3'd5, 1'b0};
      rom[1] = {3'd3, 1'b1};
      rom[2] = {3'd6, 1'b0};
      rst = 1'b1; start = 1'b0; stop = 1'b0; tone_ready = 1'b1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_rom_addr", rom_addr, 5'd0);
      check("rst_tone_valid", tone_valid, 1'b0);
      check("rst_tone_note", tone_note, 3'd0);
      check("rst_tone_gate", tone_gate, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_loop_count", loop_count, 8'd0);
      @(posedge clk); #1 rst = 1'b0;

      // start and stop together while idle
      @(posedge clk); #1 start = 1'b1; stop = 1'b1;
      @(posedge clk); #1 start = 1'b0; stop = 1'b0;
      @(negedge clk);
      check("idle_start_stop_busy", busy, 1'b0);
      check("idle_start_stop_state", state_dbg, S_IDLE);

      // full song with latency check
`ifdef NOTE_SEQUENCER_LOOP_EN
      play(3);
`else
      play(1);
`endif
      pulse_start();
      @(negedge clk);
      check("lat_fetch_valid", tone_valid, 1'b0);
      check("lat_fetch_busy", busy, 1'b1);
      @(negedge clk);
      check("lat_wait_valid", tone_valid, 1'b0);
      @(negedge clk);
      check("lat_load_valid", tone_valid, 1'b1);
      check("lat_load_note", tone_note, 3'd5);
`ifdef NOTE_SEQUENCER_LOOP_EN
      finish_song(3);
      check("loop_count_three", loop_count, 8'd3);
`else
      finish_song(1);
`endif

      // generator back-pressure in LOAD
      tone_ready = 1'b0;
      play(1);
      pulse_start();
      for (int i = 0; i < LIMIT && tone_valid !== 1'b1; i++) @(negedge clk);
      check("bp_valid_seen", tone_valid, 1'b1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("bp_valid_held", tone_valid, 1'b1);
         check("bp_note_stable", tone_note, 3'd5);
         check("bp_gate_low", tone_gate, 1'b0);
      end
      @(posedge clk); #1 tone_ready = 1'b1;
      @(negedge clk);
      check("bp_not_yet_note", tone_gate, 1'b0);
      @(negedge clk);
      check("bp_note_gate", tone_gate, 1'b1);
      check("bp_valid_dropped", tone_valid, 1'b0);
      finish_song(1);

      // stop during the second note, then replay from the top
      addr_exp_q.push_back(5'd0);
      addr_exp_q.push_back(5'd1);
      note_exp_q.push_back({rom[0][3:1], 6'(SHORT_UNITS * BEAT_SAMPLES)});
      pulse_start();
      for (int i = 0; i < LIMIT && !(tone_gate === 1'b1 && tone_note === 3'd3); i++) @(negedge clk);
      check("second_note_playing", {tone_gate, tone_note}, {1'b1, 3'd3});
      repeat (6) @(posedge clk);
      pulse_stop();
      @(negedge clk);
      check("stop_busy", busy, 1'b0);
      check("stop_gate", tone_gate, 1'b0);
      check("stop_valid", tone_valid, 1'b0);
      play(1);
      pulse_start();
      finish_song(1);

      // reset mid-note with a simultaneous start
      addr_exp_q.push_back(5'd0);
      pulse_start();
      for (int i = 0; i < LIMIT && tone_gate !== 1'b1; i++) @(negedge clk);
      check("rst_test_gate_on", tone_gate, 1'b1);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1; start = 1'b1;
      @(posedge clk); #1 rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check("midrst_state", state_dbg, S_IDLE);
      check("midrst_gate", tone_gate, 1'b0);
      check("midrst_valid", tone_valid, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_rom_addr", rom_addr, 5'd0);
      check("midrst_tone_note", tone_note, 3'd0);
      check("midrst_loop_count", loop_count, 8'd0);
      repeat (4) @(negedge clk);
      check("midrst_stays_idle", busy, 1'b0);

      check("note_queue_drained", note_exp_q.size(), 0);
      check("addr_queue_drained", addr_exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter SONG_LEN, default 25: number of melody ROM entries (1..32).
REQ-002 Parameter BEAT_SAMPLES, default 5468: sample_tick pulses per timing unit.
REQ-003 Parameter SHORT_UNITS, default 3; LONG_UNITS, default 7; GAP_UNITS, default 1: note/space lengths in units.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 sample_tick  in  1  one-cycle strobe at sample rate.
REQ-007 start  in  1  one-cycle request to begin playback at entry 0.
REQ-008 stop  in  1  one-cycle request to abort playback.
REQ-009 rom_addr  out  5  melody ROM address.
REQ-010 rom_data  in  4  ROM word: [3:1] note code, [0] length (0 short, 1 long); valid exactly 1 cycle after rom_addr changes.
REQ-011 tone_valid  out  1  note code offered to tone generator.
REQ-012 tone_ready  in  1  tone generator accepts tone_note when high with tone_valid.
REQ-013 tone_note  out  3  note code to tone generator.
REQ-014 tone_gate  out  1  high while the accumulator shall advance (note sounding).
REQ-015 busy  out  1  high in any state except IDLE.
REQ-016 loop_count  out  8  completed song passes, wraps 255->0.

Function
REQ-017 FSM states: IDLE, FETCH, WAIT_DATA, LOAD, NOTE, GAP.
REQ-018 IDLE: start -> FETCH with pos=0; all else ignored.
REQ-019 FETCH: rom_addr=pos, -> WAIT_DATA; WAIT_DATA: latch rom_data into note/length regs, -> LOAD.
REQ-020 LOAD: tone_valid=1, tone_note=latched note; stays until tone_valid&tone_ready, then -> NOTE next cycle; tone_note stable while waiting.
REQ-021 NOTE: tone_gate=1; after SHORT_UNITS or LONG_UNITS units (per length bit) -> GAP with tone_gate=0 in that cycle.
REQ-022 GAP: after GAP_UNITS units, pos<SONG_LEN-1 -> pos+1, FETCH; pos==SONG_LEN-1 -> end-of-song (REQ-036).
REQ-023 Unit: sample counter counts sample_tick only in NOTE/GAP, cleared on entering NOTE or GAP; unit completes on the sample_tick where counter==BEAT_SAMPLES-1.
REQ-024 Unit counter cleared on state entry; state ends on the unit completion reaching the target count.
REQ-025 sample_tick in FETCH/WAIT_DATA/LOAD/IDLE is ignored; tone_gate low there.
REQ-026 stop in any non-IDLE state -> IDLE next cycle, tone_gate and tone_valid low that cycle; stop wins over simultaneous start or unit completion.
REQ-027 start while busy ignored.
REQ-028 tone_ready high outside LOAD has no effect.
REQ-029 Note latency: start at cycle 0 -> tone_valid at cycle 3 (FETCH 1, WAIT_DATA 2, LOAD 3).
REQ-030 All outputs registered; counter widths sized from parameters by $clog2, no truncation.

Reset
REQ-031 rst (sync) -> state IDLE, pos=0, counters 0, loop_count=0.
REQ-032 Outputs during/after reset: rom_addr=0, tone_valid=0, tone_note=0, tone_gate=0, busy=0.
REQ-033 rst asserted mid-note has priority over start/stop/ticks; tone_gate low next cycle.

Configuration
REQ-034 Macro NOTE_SEQUENCER_LOOP_EN selects end-of-song behaviour.
REQ-035 Defined: end-of-song -> pos=0, loop_count+1, FETCH (continuous looping).
REQ-036 Undefined: end-of-song -> IDLE, busy=0; loop_count held at 0.

Verification (bench params SONG_LEN=3, BEAT_SAMPLES=4, SHORT_UNITS=3, LONG_UNITS=7, GAP_UNITS=1, sample_tick every 2nd cycle, tone_ready=1)
REQ-037 ROM {short, long, short}, start -> tone_gate high for exactly 12, 28, 12 sample_ticks, low 4 ticks between; tone_note matches ROM codes.
REQ-038 tone_ready held low 10 cycles in LOAD -> tone_valid held, tone_note stable, tone_gate low; NOTE begins the cycle after ready rises.
REQ-039 stop during second note -> busy, tone_gate low next cycle; later start replays from rom_addr=0.
REQ-040 With LOOP_EN: 3 full passes -> loop_count=3, rom_addr sequence 0,1,2,0...; without: busy drops after pass 1, loop_count=0.
REQ-041 rst asserted mid-NOTE with start same cycle -> all outputs at reset values, state IDLE.
REQ-042 start and stop same cycle in IDLE -> remains IDLE, busy=0.
